// File: rtl/rx_pam4_slicer_ber_if.sv
// ============================================================================
// Module   : rx_pam4_slicer_ber_if
// Brief    : Sample/reference/control bundle for the PAM-4 slicer and BER
//            counter. The bit_err_count member exists only with RX_BIT_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_pam4_slicer_ber_if #(
    parameter int CNT_W = 32
);
    logic                    en;
    logic [1:0]              tx_sym;
    logic                    tx_sym_valid;
    logic signed [7:0]       rx_in;
    logic                    rx_in_valid;
    logic                    start;
    logic [1:0]              rx_sym;
    logic                    rx_sym_valid;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        err_count;
    logic [CNT_W-1:0]        sym_count;
    logic                    overflow;
    logic                    underflow;
`ifdef RX_BIT_ERR_EN
    logic [CNT_W-1:0]        bit_err_count;
`endif

    modport master (
        output en, tx_sym, tx_sym_valid, rx_in, rx_in_valid, start,
`ifdef RX_BIT_ERR_EN
        input  bit_err_count,
`endif
        input  rx_sym, rx_sym_valid, busy, done, err_count, sym_count,
               overflow, underflow
    );

    modport slave (
        input  en, tx_sym, tx_sym_valid, rx_in, rx_in_valid, start,
`ifdef RX_BIT_ERR_EN
        output bit_err_count,
`endif
        output rx_sym, rx_sym_valid, busy, done, err_count, sym_count,
               overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/rx_pam4_slicer_ber.sv
// ============================================================================
// Module   : rx_pam4_slicer_ber
// Brief    : Slices signed PAM-4 samples, aligns them to the reference stream
//            through a FIFO and counts symbol errors over a window.
//            Optional macro RX_BIT_ERR_EN adds a Hamming-distance bit counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_pam4_slicer_ber #(
    parameter int DEPTH   = 16,
    parameter int WINDOW  = 1024,
    parameter int CNT_W   = 32,
    parameter int THR_LO  = -32,
    parameter int THR_MID = 0,
    parameter int THR_HI  = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    rx_pam4_slicer_ber_if.slave    bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic signed [7:0] c_thr_lo  = THR_LO[7:0];
    localparam logic signed [7:0] c_thr_mid = THR_MID[7:0];
    localparam logic signed [7:0] c_thr_hi  = THR_HI[7:0];
    localparam logic [CNT_W-1:0]  c_win_last = CNT_W'(WINDOW - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MEASURE = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [1:0]       mem_q [DEPTH];
    logic [1:0]       rx_sym_q;
    logic             rx_sym_valid_q;
    logic [CNT_W-1:0] sym_q, sym_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             w_push_req, w_pop_req;
    logic             w_full, w_empty;
    logic             w_do_push, w_do_pop;
    logic             w_cmp, w_clear;
    logic [1:0]       w_slice, w_head;
    logic             w_busy, w_done;

    // ---------------- slicer ----------------
    always_comb begin
        if (bus.rx_in < c_thr_lo)
            w_slice = 2'b00;
        else if (bus.rx_in < c_thr_mid)
            w_slice = 2'b01;
        else if (bus.rx_in < c_thr_hi)
            w_slice = 2'b10;
        else
            w_slice = 2'b11;
    end

    // ---------------- reference FIFO ----------------
    assign w_push_req = bus.en & bus.tx_sym_valid;
    assign w_pop_req  = bus.en & bus.rx_in_valid;
    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign w_do_pop   = w_pop_req & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push  = w_push_req & (~w_full | w_do_pop);
    assign w_head     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push)
            mem_q[wr_ptr_q[AW-1:0]] <= bus.tx_sym;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------- measurement FSM ----------------
    assign w_cmp   = w_do_pop & (state_q == c_MEASURE);
    assign w_clear = bus.en & bus.start & (state_q != c_MEASURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= c_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:    if (w_clear) state_d = c_MEASURE;
            c_MEASURE: if (w_cmp && (sym_q == c_win_last)) state_d = c_DONE;
            c_DONE:    if (w_clear) state_d = c_MEASURE;
            default:   state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (state_q)
            c_MEASURE: w_busy = 1'b1;
            c_DONE:    w_done = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- counters and sticky flags ----------------
    always_comb begin
        sym_d = sym_q;
        err_d = err_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (w_clear) begin
            sym_d = '0;
            err_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (w_cmp) begin
            sym_d = sym_q + 1'b1;
            if ((w_slice != w_head) && (err_q != '1))
                err_d = err_q + 1'b1;
        end
        if (w_push_req && w_full && !w_do_pop)
            ovf_d = 1'b1;
        if (w_pop_req && w_empty)
            unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_q          <= '0;
            err_q          <= '0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
            rx_sym_q       <= 2'b00;
            rx_sym_valid_q <= 1'b0;
        end else begin
            sym_q          <= sym_d;
            err_q          <= err_d;
            ovf_q          <= ovf_d;
            unf_q          <= unf_d;
            rx_sym_valid_q <= w_pop_req;
            if (w_pop_req)
                rx_sym_q <= w_slice;
        end
    end

`ifdef RX_BIT_ERR_EN
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [1:0]       w_diff;
    logic [1:0]       w_ham;
    logic [CNT_W:0]   w_bit_sum;

    assign w_diff    = w_slice ^ w_head;
    assign w_ham     = {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
    assign w_bit_sum = {1'b0, bit_q} + {{(CNT_W-1){1'b0}}, w_ham};

    always_comb begin
        bit_d = bit_q;
        if (w_clear)
            bit_d = '0;
        if (w_cmp)
            bit_d = w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bit_q <= '0;
        else
            bit_q <= bit_d;
    end

    assign bus.bit_err_count = bit_q;
`endif

    assign bus.rx_sym       = rx_sym_q;
    assign bus.rx_sym_valid = rx_sym_valid_q;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.err_count    = err_q;
    assign bus.sym_count    = sym_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_pam4_slicer_ber.sv
// ============================================================================
// Module   : tb_rx_pam4_slicer_ber
// Brief    : Directed self-checking bench for rx_pam4_slicer_ber (DEPTH=4,
//            WINDOW=8). Honours RX_BIT_ERR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_pam4_slicer_ber;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rx_pam4_slicer_ber_if #(.CNT_W(32)) bus ();

    rx_pam4_slicer_ber #(
        .DEPTH   (4),
        .WINDOW  (8),
        .CNT_W   (32),
        .THR_LO  (-32),
        .THR_MID (0),
        .THR_HI  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        tx_pat   [8];
    logic signed [7:0] rx_clean [8];
    logic signed [7:0] rx_err   [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tx_sym_valid = 1'b0;
        bus.rx_in_valid  = 1'b0;
        bus.start        = 1'b0;
    endtask

    // Reference symbol i pushed on cycle i, matching sample popped on cycle i+1
    task automatic run_stream(input logic signed [7:0] r [8]);
        for (int i = 0; i <= 8; i++) begin
            bus.tx_sym_valid = (i < 8);
            bus.tx_sym       = tx_pat[(i < 8) ? i : 0];
            bus.rx_in_valid  = (i > 0);
            bus.rx_in        = r[(i > 0) ? i - 1 : 0];
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.tx_sym = 2'b00;
        bus.rx_in = 8'sd0;
        idle_inputs();
        step();
        step();
        checks++;
        if ({bus.rx_sym, bus.rx_sym_valid, bus.busy, bus.done, bus.overflow, bus.underflow} !== 7'd0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000000",
                     {bus.rx_sym, bus.rx_sym_valid, bus.busy, bus.done, bus.overflow, bus.underflow});
        end
        checks++;
        if (bus.sym_count !== 32'd0 || bus.err_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts got sym=%0d err=%0d exp 0 0", bus.sym_count, bus.err_count);
        end
`ifdef RX_BIT_ERR_EN
        checks++;
        if (bus.bit_err_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_bit_err got %0d exp 0", bus.bit_err_count);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_slicer();
        logic signed [7:0] vin [8];
        logic [1:0]        vexp [8];
        vin  = '{-8'sd128, -8'sd33, -8'sd32, -8'sd1, 8'sd0, 8'sd31, 8'sd32, 8'sd127};
        vexp = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        for (int i = 0; i < 8; i++) begin
            bus.rx_in_valid = 1'b1;
            bus.rx_in       = vin[i];
            step();
            checks++;
            if (bus.rx_sym !== vexp[i] || bus.rx_sym_valid !== 1'b1) begin
                errors++;
                $display("FAIL slicer_%0d got sym=%b vld=%b exp sym=%b vld=1",
                         vin[i], bus.rx_sym, bus.rx_sym_valid, vexp[i]);
            end
        end
        bus.rx_in_valid = 1'b0;
        bus.rx_in       = -8'sd100;
        step();
        checks++;
        if (bus.rx_sym !== 2'b11 || bus.rx_sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL slicer_hold got sym=%b vld=%b exp sym=11 vld=0", bus.rx_sym, bus.rx_sym_valid);
        end
    endtask

    task automatic test_clean_window();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.underflow !== 1'b0 || bus.sym_count !== 32'd0) begin
            errors++;
            $display("FAIL clean_start got busy=%b unf=%b sym=%0d exp 1 0 0",
                     bus.busy, bus.underflow, bus.sym_count);
        end
        run_stream(rx_clean);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_done got done=%b busy=%b exp 1 0", bus.done, bus.busy);
        end
        checks++;
        if (bus.sym_count !== 32'd8 || bus.err_count !== 32'd0) begin
            errors++;
            $display("FAIL clean_counts got sym=%0d err=%0d exp 8 0", bus.sym_count, bus.err_count);
        end
    endtask

    task automatic test_errors();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.sym_count !== 32'd0 || bus.err_count !== 32'd0) begin
            errors++;
            $display("FAIL restart got busy=%b done=%b sym=%0d err=%0d exp 1 0 0 0",
                     bus.busy, bus.done, bus.sym_count, bus.err_count);
        end
        run_stream(rx_err);
        checks++;
        if (bus.err_count !== 32'd2 || bus.sym_count !== 32'd8 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL err_window got err=%0d sym=%0d done=%b exp 2 8 1",
                     bus.err_count, bus.sym_count, bus.done);
        end
`ifdef RX_BIT_ERR_EN
        checks++;
        if (bus.bit_err_count !== 32'd3) begin
            errors++;
            $display("FAIL bit_err got %0d exp 3", bus.bit_err_count);
        end
`endif
    endtask

    task automatic test_overflow_underflow();
        logic [1:0]        push_seq [5];
        logic signed [7:0] pop_rx   [4];
        push_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        pop_rx   = '{-8'sd16, 8'sd16, 8'sd48, 8'sd16};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_start got ovf=%b unf=%b busy=%b exp 0 0 1",
                     bus.overflow, bus.underflow, bus.busy);
        end
        for (int i = 0; i < 5; i++) begin
            bus.tx_sym_valid = 1'b1;
            bus.tx_sym       = push_seq[i];
            step();
            if (i == 3) begin
                checks++;
                if (bus.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at_full got %b exp 0", bus.overflow);
                end
            end
        end
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b exp 1", bus.overflow);
        end
        // Full: push 2 while popping head 0
        bus.tx_sym = 2'd2;
        bus.rx_in_valid = 1'b1;
        bus.rx_in = -8'sd48;
        step();
        bus.tx_sym_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = pop_rx[i];
            step();
        end
        checks++;
        if (bus.sym_count !== 32'd5 || bus.err_count !== 32'd0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pops got sym=%0d err=%0d unf=%b exp 5 0 0",
                     bus.sym_count, bus.err_count, bus.underflow);
        end
        bus.rx_in = 8'sd127;
        step();
        bus.rx_in_valid = 1'b0;
        checks++;
        if (bus.rx_sym_valid !== 1'b1 || bus.rx_sym !== 2'b11 || bus.underflow !== 1'b1 || bus.sym_count !== 32'd5) begin
            errors++;
            $display("FAIL underflow got vld=%b sym=%b unf=%b cnt=%0d exp 1 11 1 5",
                     bus.rx_sym_valid, bus.rx_sym, bus.underflow, bus.sym_count);
        end
    endtask

    task automatic test_enable();
        bus.en = 1'b0;
        bus.tx_sym_valid = 1'b1;
        bus.tx_sym = 2'd1;
        bus.rx_in_valid = 1'b1;
        bus.rx_in = -8'sd16;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.rx_sym_valid !== 1'b0 || bus.sym_count !== 32'd5 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL en_low_%0d got vld=%b sym=%0d busy=%b exp 0 5 1",
                         i, bus.rx_sym_valid, bus.sym_count, bus.busy);
            end
        end
        bus.en = 1'b1;
        bus.start = 1'b0;
        bus.tx_sym_valid = 1'b0;
        bus.rx_in = -8'sd48;
        step();
        bus.rx_in_valid = 1'b0;
        checks++;
        if (bus.sym_count !== 32'd5 || bus.rx_sym_valid !== 1'b1 || bus.rx_sym !== 2'b00) begin
            errors++;
            $display("FAIL en_no_push got sym=%0d vld=%b rx=%b exp 5 1 00",
                     bus.sym_count, bus.rx_sym_valid, bus.rx_sym);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.tx_sym_valid = 1'b1;
            bus.tx_sym       = tx_pat[i];
            bus.rx_in_valid  = (i > 0);
            bus.rx_in        = rx_clean[(i > 0) ? i - 1 : 0];
            step();
        end
        idle_inputs();
        checks++;
        if (bus.sym_count !== 32'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got sym=%0d busy=%b exp 3 1", bus.sym_count, bus.busy);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({bus.rx_sym, bus.rx_sym_valid, bus.busy, bus.done, bus.overflow, bus.underflow} !== 7'd0 ||
            bus.sym_count !== 32'd0 || bus.err_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b sym=%0d err=%0d exp 0 0 0",
                     {bus.rx_sym, bus.rx_sym_valid, bus.busy, bus.done, bus.overflow, bus.underflow},
                     bus.sym_count, bus.err_count);
        end
        step();
        rst = 1'b0;
        bus.rx_in_valid = 1'b1;
        bus.rx_in = 8'sd48;
        step();
        bus.rx_in_valid = 1'b0;
        checks++;
        if (bus.underflow !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_fifo_empty got unf=%b busy=%b exp 1 0", bus.underflow, bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tx_pat   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        rx_clean = '{-8'sd48, -8'sd16, 8'sd16, 8'sd48, -8'sd48, -8'sd16, 8'sd16, 8'sd48};
        rx_err   = '{-8'sd48, -8'sd16, -8'sd16, 8'sd48, -8'sd48, 8'sd60, 8'sd16, 8'sd48};
        test_reset();
        test_slicer();
        test_clean_window();
        test_errors();
        test_overflow_underflow();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/rx_pam4_slicer_ber.md
Name: rx_pam4_slicer_ber

Overview:
- Downstream stage of the noise-injection block.
- Slices noisy 8-bit signed PAM-4 samples into 2-bit symbols.
- Aligns each sliced symbol with the transmitted reference symbol through an internal FIFO, and counts symbol errors over a programmable measurement window.
- Feeds the BER statistics consumed by the Rx sim top and the Matlab comparison scripts.

Parameters:
- DEPTH, 16: reference-symbol FIFO depth (power of 2, ≥2).
- WINDOW, 1024: symbols compared per measurement (≥1).
- CNT_W, 32: width of the counters; 2^CNT_W-1 ≥ WINDOW.
- THR_LO, -32: lower slicer threshold (signed 8-bit).
- THR_MID, 0: middle slicer threshold.
- THR_HI, 32: upper slicer threshold; THR_LO < THR_MID < THR_HI.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  global enable; when 0 nothing advances.
- tx_sym  in  2  transmitted reference symbol.
- tx_sym_valid  in  1  push tx_sym into the FIFO.
- rx_in  in  8  signed noisy sample (noise stage output).
- rx_in_valid  in  1  rx_in valid; pops one reference symbol.
- start  in  1  single-cycle measurement start request.
- rx_sym  out  2  sliced symbol.
- rx_sym_valid  out  1  rx_sym valid, 1-cycle pulse.
- busy  out  1  high in MEASURE.
- done  out  1  high in DONE.
- err_count  out  CNT_W  symbol mismatches in the current or last window.
- sym_count  out  CNT_W  symbols compared in the current or last window.
- overflow  out  1  sticky: push dropped because the FIFO was full.
- underflow  out  1  sticky: rx_in_valid arrived with the FIFO empty.

Behaviour:
- Reset values:
  - All outputs are 0.
  - The FIFO is empty.
  - The state machine is in IDLE.
- Slicer (signed compare):
  - rx_in < THR_LO gives 2'b00.
  - THR_LO ≤ rx_in < THR_MID gives 2'b01.
  - THR_MID ≤ rx_in < THR_HI gives 2'b10.
  - rx_in ≥ THR_HI gives 2'b11.
- Latency: with en=1 and rx_in_valid=1 at edge N, rx_sym and rx_sym_valid=1 are presented after edge N. Counter updates from that sample are visible after the same edge N. rx_sym holds its value when no new sample arrives.
- FIFO (all operations gated by en):
  - Push on tx_sym_valid.
  - Pop on rx_in_valid.
  - Pointers wrap modulo DEPTH.
  - Full with push and pop in the same cycle: both occur, occupancy unchanged.
  - Full with push only: the symbol is dropped and overflow is set.
  - Empty with rx_in_valid: the sample is still sliced and output but is not compared, underflow is set, and any simultaneous push is stored (no bypass).
- Comparison: only a popped, non-empty FIFO head is compared, and only while in MEASURE. sym_count increments by 1; err_count increments by 1 if rx_sym ≠ head. err_count saturates at all-ones.
- State machine:
  - IDLE, on start: clear counters and sticky flags, go to MEASURE.
  - MEASURE: compare symbols. On the edge where sym_count reaches WINDOW, go to DONE. start is ignored in MEASURE.
  - DONE: counters and flags hold. On start: clear and go to MEASURE.
- The FIFO keeps running in all states, so alignment is preserved across windows.
- en=0: no push, no pop, no state change, no counter update; rx_sym_valid=0; all other outputs hold.
- rst mid-measurement: immediate return to reset values; FIFO contents are discarded.

Optional Feature:
- Macro RX_BIT_ERR_EN.
- When defined:
  - Adds output port bit_err_count (CNT_W bits).
  - In MEASURE, each compared symbol adds the Hamming distance (0–2) between rx_sym and the FIFO head.
  - The count saturates at all-ones, is cleared with the other counters, and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Slicer thresholds: rx_in = -128, -33, -32, -1, 0, 31, 32, 127 -> rx_sym = 00, 00, 01, 01, 10, 10, 11, 11, each valid one cycle after input.
- Clean window:
  - WINDOW=8; start; push tx 0,1,2,3,0,1,2,3 with matching rx_in -48,-16,16,48,…
  - -> done=1 after the 8th sample; sym_count=8; err_count=0; busy goes low in the same cycle.
- Errors:
  - Same stream, but rx_in[2]=-16 (slices to 01 vs tx 10) and rx_in[5]=60 (slices to 11 vs tx 01).
  - -> err_count=2, sym_count=8.
  - With RX_BIT_ERR_EN: bit_err_count=3.
- Overflow:
  - DEPTH=4; push 5 symbols with no rx_in_valid.
  - -> overflow=1; the 5th symbol is dropped; the next 4 pops return the first 4.
  - Push and pop together while full -> no further drop.
- Underflow and restart:
  - rx_in_valid with the FIFO empty -> rx_sym_valid=1, underflow=1, sym_count unchanged.
  - start in DONE -> counters and flags clear, busy=1.
- Reset and enable:
  - Assert rst mid-MEASURE (sym_count=3) -> all outputs 0 immediately, FIFO empty.
  - en=0 for 5 cycles with valids high -> no counts, rx_sym_valid=0.
